// File: rtl/vend_pkg.sv
// Shared vending-machine types and constants.
// Used by the coin front-end, the vending FSM and their benches.
package vend_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_t;

  localparam int COUNT_W = 8;

endpackage

// File: rtl/coin_debounce.sv
// One sensor line: 2-flop synchroniser, debounce counter and
// rising-edge detector on the debounced level.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else cnt_d = cnt_q + CW'(1);
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front-end: debounces both sensors, arbitrates them,
// enforces a hold-off and emits exclusive accept/reject pulses.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sense_five,
  input  logic               sense_ten,
  input  logic               enable,
  output logic               five_coin,
  output logic               ten_coin,
  output logic               reject,
  output logic [COUNT_W-1:0] coin_count
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic five_level, five_rise;
  logic ten_level, ten_rise;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_five (
    .clk   (clk),
    .reset (reset),
    .raw   (sense_five),
    .level (five_level),
    .rise  (five_rise)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ten (
    .clk   (clk),
    .reset (reset),
    .raw   (sense_ten),
    .level (ten_level),
    .rise  (ten_rise)
  );

  state_t             state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               five_q, five_d;
  logic               ten_q, ten_d;
  logic               rej_q, rej_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ev_any, ev_both;

  assign ev_any  = five_rise | ten_rise;
  assign ev_both = five_rise & ten_rise;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    five_d  = 1'b0;
    ten_d   = 1'b0;
    rej_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (ev_any) begin
          state_d = HOLD;
          gap_d   = '0;
          if (ev_both || !enable) begin
            rej_d = 1'b1;
          end else begin
            five_d  = five_rise;
            ten_d   = ten_rise;
            count_d = count_q + COUNT_W'(1);
          end
        end
      end
      HOLD: begin
        rej_d = ev_any;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      five_q  <= 1'b0;
      ten_q   <= 1'b0;
      rej_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      five_q  <= five_d;
      ten_q   <= ten_d;
      rej_q   <= rej_d;
      count_q <= count_d;
    end
  end

  assign five_coin  = five_q;
  assign ten_coin   = ten_q;
  assign reject     = rej_q;
  assign coin_count = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, GAP_CYCLES=3.
// A clean raw rise lands its pulse 7 edges later.
module tb_coin_acceptor;
  import vend_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sense_five = 1'b0;
  logic               sense_ten = 1'b0;
  logic               enable = 1'b1;
  logic               five_coin, ten_coin, reject;
  logic [COUNT_W-1:0] coin_count;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_five, n_ten, n_rej;
  int t_five, t_ten, t_rej;
  int c_five, c_ten;
  int c0;

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES(3)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .sense_five (sense_five),
    .sense_ten  (sense_ten),
    .enable     (enable),
    .five_coin  (five_coin),
    .ten_coin   (ten_coin),
    .reject     (reject),
    .coin_count (coin_count)
  );

  task automatic clr();
    n_five = 0; n_ten = 0; n_rej = 0;
    t_five = -1; t_ten = -1; t_rej = -1;
    c_five = -1; c_ten = -1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (five_coin) begin n_five++; t_five = cyc; c_five = int'(coin_count); end
      if (ten_coin) begin n_ten++; t_ten = cyc; c_ten = int'(coin_count); end
      if (reject) begin n_rej++; t_rej = cyc; end
      n_assert++;
      if ($countones({five_coin, ten_coin, reject}) > 1) begin
        n_fail++;
        $display("FAIL exclusive cyc=%0d got five=%b ten=%b rej=%b want at most one",
                 cyc, five_coin, ten_coin, reject);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    n_assert++;
    if (five_coin !== 1'b0) begin n_fail++; $display("FAIL rst_five got %b want 0", five_coin); end
    n_assert++;
    if (ten_coin !== 1'b0) begin n_fail++; $display("FAIL rst_ten got %b want 0", ten_coin); end
    n_assert++;
    if (reject !== 1'b0) begin n_fail++; $display("FAIL rst_rej got %b want 0", reject); end
    n_assert++;
    if (coin_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", coin_count); end
    reset = 1'b0;
    step(3);
  endtask

  task automatic test_single();
    clr();
    c0 = cyc;
    sense_five = 1'b1;
    step(10);
    sense_five = 1'b0;
    step(15);
    n_assert++;
    if (n_five !== 1) begin n_fail++; $display("FAIL single_n got %0d want 1", n_five); end
    n_assert++;
    if (t_five !== c0 + 7) begin n_fail++; $display("FAIL single_lat got %0d want %0d", t_five, c0 + 7); end
    n_assert++;
    if (c_five !== 1) begin n_fail++; $display("FAIL single_cnt_edge got %0d want 1", c_five); end
    n_assert++;
    if (n_rej !== 0 || n_ten !== 0) begin
      n_fail++; $display("FAIL single_other got rej=%0d ten=%0d want 0", n_rej, n_ten);
    end
    n_assert++;
    if (coin_count !== 8'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", coin_count); end
  endtask

  task automatic test_glitch();
    clr();
    sense_ten = 1'b1;
    step(3);
    sense_ten = 1'b0;
    step(15);
    n_assert++;
    if (n_five + n_ten + n_rej !== 0) begin
      n_fail++; $display("FAIL glitch_pulses got %0d want 0", n_five + n_ten + n_rej);
    end
    n_assert++;
    if (coin_count !== 8'd1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", coin_count); end
  endtask

  task automatic test_simultaneous();
    clr();
    c0 = cyc;
    sense_five = 1'b1;
    sense_ten = 1'b1;
    step(8);
    sense_five = 1'b0;
    sense_ten = 1'b0;
    step(20);
    n_assert++;
    if (n_rej !== 1) begin n_fail++; $display("FAIL sim_rej got %0d want 1", n_rej); end
    n_assert++;
    if (t_rej !== c0 + 7) begin n_fail++; $display("FAIL sim_lat got %0d want %0d", t_rej, c0 + 7); end
    n_assert++;
    if (n_five !== 0 || n_ten !== 0) begin
      n_fail++; $display("FAIL sim_coin got five=%0d ten=%0d want 0", n_five, n_ten);
    end
    n_assert++;
    if (coin_count !== 8'd1) begin n_fail++; $display("FAIL sim_count got %0d want 1", coin_count); end
  endtask

  task automatic test_holdoff();
    clr();
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) sense_five = 1'b1;
      if (i == 2) sense_ten = 1'b1;
      if (i == 8) sense_five = 1'b0;
      if (i == 10) sense_ten = 1'b0;
      step(1);
    end
    step(15);
    n_assert++;
    if (n_five !== 1 || t_five !== c0 + 7) begin
      n_fail++; $display("FAIL hold_five got n=%0d t=%0d want n=1 t=%0d", n_five, t_five, c0 + 7);
    end
    n_assert++;
    if (n_rej !== 1 || t_rej !== c0 + 9) begin
      n_fail++; $display("FAIL hold_rej got n=%0d t=%0d want n=1 t=%0d", n_rej, t_rej, c0 + 9);
    end
    n_assert++;
    if (n_ten !== 0) begin n_fail++; $display("FAIL hold_ten got %0d want 0", n_ten); end
    n_assert++;
    if (coin_count !== 8'd2) begin n_fail++; $display("FAIL hold_count got %0d want 2", coin_count); end
  endtask

  task automatic test_disabled();
    clr();
    c0 = cyc;
    enable = 1'b0;
    sense_ten = 1'b1;
    step(8);
    sense_ten = 1'b0;
    step(20);
    n_assert++;
    if (n_rej !== 1 || t_rej !== c0 + 7) begin
      n_fail++; $display("FAIL dis_rej got n=%0d t=%0d want n=1 t=%0d", n_rej, t_rej, c0 + 7);
    end
    n_assert++;
    if (n_ten !== 0 || n_five !== 0) begin
      n_fail++; $display("FAIL dis_coin got ten=%0d five=%0d want 0", n_ten, n_five);
    end
    n_assert++;
    if (coin_count !== 8'd2) begin n_fail++; $display("FAIL dis_count got %0d want 2", coin_count); end
    clr();
    enable = 1'b1;
    c0 = cyc;
    sense_ten = 1'b1;
    step(8);
    sense_ten = 1'b0;
    step(20);
    n_assert++;
    if (n_ten !== 1 || t_ten !== c0 + 7) begin
      n_fail++; $display("FAIL en_ten got n=%0d t=%0d want n=1 t=%0d", n_ten, t_ten, c0 + 7);
    end
    n_assert++;
    if (c_ten !== 3) begin n_fail++; $display("FAIL en_cnt_edge got %0d want 3", c_ten); end
    n_assert++;
    if (n_rej !== 0) begin n_fail++; $display("FAIL en_rej got %0d want 0", n_rej); end
  endtask

  task automatic test_reset_mid();
    clr();
    sense_ten = 1'b1;
    step(4);
    reset = 1'b1;
    #1;
    n_assert++;
    if (coin_count !== 8'd0) begin n_fail++; $display("FAIL rmid_count got %0d want 0", coin_count); end
    n_assert++;
    if ({five_coin, ten_coin, reject} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_outs got %b want 000", {five_coin, ten_coin, reject});
    end
    step(2);
    reset = 1'b0;
    n_assert++;
    if (n_five + n_ten + n_rej !== 0) begin
      n_fail++; $display("FAIL rmid_during got %0d want 0", n_five + n_ten + n_rej);
    end
    c0 = cyc;
    step(12);
    n_assert++;
    if (n_ten !== 1 || t_ten !== c0 + 7) begin
      n_fail++; $display("FAIL rmid_fresh got n=%0d t=%0d want n=1 t=%0d", n_ten, t_ten, c0 + 7);
    end
    n_assert++;
    if (coin_count !== 8'd1) begin n_fail++; $display("FAIL rmid_count2 got %0d want 1", coin_count); end
    sense_ten = 1'b0;
    step(15);
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    clr();
    for (int k = 0; k < 256; k++) begin
      sense_five = 1'b1;
      step(6);
      sense_five = 1'b0;
      step(8);
      if (k == 254) begin
        n_assert++;
        if (coin_count !== 8'd255) begin
          n_fail++; $display("FAIL wrap_255 got %0d want 255", coin_count);
        end
      end
    end
    n_assert++;
    if (coin_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got %0d want 0", coin_count); end
    n_assert++;
    if (n_five !== 256) begin n_fail++; $display("FAIL wrap_n got %0d want 256", n_five); end
    n_assert++;
    if (n_rej !== 0) begin n_fail++; $display("FAIL wrap_rej got %0d want 0", n_rej); end
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_glitch();
    test_simultaneous();
    test_holdoff();
    test_disabled();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
